// File: rtl/window3x3_linebuf_pkg.sv
// Shared constants, FSM state type and tap-offset helper for the 3x3 window generator.
package window3x3_linebuf_pkg;

  localparam int unsigned FP_WIDTH = 32;
  localparam int unsigned TAPS_3x3 = 9;

  typedef enum logic [1:0] {
    FILL,
    STREAM,
    FLUSH
  } state_e;

  // Distance of tap k from the newest chain entry; k=0 is the oldest (top-left).
  function automatic int unsigned tap_off(input int unsigned k, input int unsigned w);
    return (2 - k / 3) * w + (2 - k % 3);
  endfunction

endpackage

// File: rtl/window3x3_linebuf_if.sv
// Pixel-in / window-out bundle between the stream source and the window generator.
interface window3x3_linebuf_if #(
  parameter int unsigned DATA_WIDTH = window3x3_linebuf_pkg::FP_WIDTH
);
  import window3x3_linebuf_pkg::*;

  logic [DATA_WIDTH-1:0]          data_in;
  logic                           valid_in;
  logic                           ready_in;
  logic [TAPS_3x3*DATA_WIDTH-1:0] data_out;
  logic                           valid_out;
  logic                           frame_done;
  logic                           overrun;

  modport master (
    output data_in, valid_in,
    input  ready_in, data_out, valid_out, frame_done, overrun
  );

  modport slave (
    input  data_in, valid_in,
    output ready_in, data_out, valid_out, frame_done, overrun
  );

endinterface

// File: rtl/window3x3_linebuf_line_shift_reg.sv
// Enable-gated shift chain presenting the nine 3x3 taps as they will stand after the
// pending shift, so the caller can register a window in the same cycle it shifts.
module window3x3_linebuf_line_shift_reg
  import window3x3_linebuf_pkg::*;
#(
  parameter int unsigned WIDTH    = FP_WIDTH,
  parameter int unsigned IMG_SIZE = 52,
  parameter int unsigned DEPTH    = 2 * IMG_SIZE + 3
) (
  input  logic                               clk,
  input  logic                               en_i,
  input  logic [WIDTH-1:0]                   data_i,
  output logic [TAPS_3x3-1:0][WIDTH-1:0]     taps_o
);

  // Entry at offset 0 is the incoming word itself, so only DEPTH-1 words are stored.
  logic [DEPTH-2:0][WIDTH-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      chain_q <= {chain_q[DEPTH-3:0], data_i};
    end
  end

  for (genvar k = 0; k < TAPS_3x3; k++) begin : g_tap
    localparam int unsigned OFF = tap_off(k, IMG_SIZE);
    if (OFF == 0) begin : g_head
      assign taps_o[k] = data_i;
    end else begin : g_body
      assign taps_o[k] = chain_q[OFF-1];
    end
  end

endmodule

// File: rtl/window3x3_linebuf.sv
// Per-channel 3x3 zero-padded sliding-window generator over a raster IMG_SIZE^2 stream.
module window3x3_linebuf
  import window3x3_linebuf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FP_WIDTH,
  parameter int unsigned IMG_SIZE   = 52
) (
  input logic                 clk,
  input logic                 rst,
  window3x3_linebuf_if.slave  bus
);

  localparam int unsigned W     = IMG_SIZE;
  localparam int unsigned PIX   = W * W;
  localparam int unsigned DEPTH = 2 * W + 3;
  localparam int unsigned CW    = $clog2(W);
  localparam int unsigned NW    = $clog2(PIX);
  localparam int unsigned FW    = $clog2(W + 1);

  state_e          state_q, state_d;
  logic [NW-1:0]   in_cnt_q, in_cnt_d;
  logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [CW-1:0]   out_row_q, out_row_d;
  logic [CW-1:0]   out_col_q, out_col_d;
  logic            ready_q, ready_d;
  logic            overrun_q, overrun_d;
  logic            valid_out_q;
  logic            frame_done_q;
  logic [TAPS_3x3-1:0][DATA_WIDTH-1:0] data_out_q;

  logic                   accept_c;
  logic                   shift_c;
  logic                   emit_c;
  logic                   last_c;
  logic [DATA_WIDTH-1:0]  shift_data_c;
  logic [TAPS_3x3-1:0][DATA_WIDTH-1:0] taps_c;
  logic [TAPS_3x3-1:0][DATA_WIDTH-1:0] window_c;
  logic                   top_c, bot_c, left_c, right_c;

  window3x3_linebuf_line_shift_reg #(
    .WIDTH    (DATA_WIDTH),
    .IMG_SIZE (W),
    .DEPTH    (DEPTH)
  ) u_chain (
    .clk    (clk),
    .en_i   (shift_c),
    .data_i (shift_data_c),
    .taps_o (taps_c)
  );

  assign accept_c = bus.valid_in & ready_q;

  // Sequencing: fill, stream one window per accept, then flush zeros to drain the tail.
  always_comb begin
    state_d      = state_q;
    in_cnt_d     = in_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    shift_c      = 1'b0;
    emit_c       = 1'b0;
    shift_data_c = bus.data_in;
    overrun_d    = overrun_q | (bus.valid_in & ~ready_q);

    case (state_q)
      FILL: begin
        if (accept_c) begin
          shift_c  = 1'b1;
          in_cnt_d = in_cnt_q + NW'(1);
          if (in_cnt_q == NW'(W)) state_d = STREAM;
        end
      end
      STREAM: begin
        if (accept_c) begin
          shift_c = 1'b1;
          emit_c  = 1'b1;
          if (in_cnt_q == NW'(PIX - 1)) begin
            state_d  = FLUSH;
            in_cnt_d = '0;
          end else begin
            in_cnt_d = in_cnt_q + NW'(1);
          end
        end
      end
      FLUSH: begin
        shift_c      = 1'b1;
        emit_c       = 1'b1;
        shift_data_c = '0;
        if (flush_cnt_q == FW'(W)) begin
          state_d     = FILL;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + FW'(1);
        end
      end
      default: state_d = FILL;
    endcase

    if (emit_c) begin
      if (out_col_q == CW'(W - 1)) begin
        out_col_d = '0;
        out_row_d = (out_row_q == CW'(W - 1)) ? '0 : out_row_q + CW'(1);
      end else begin
        out_col_d = out_col_q + CW'(1);
      end
    end

    ready_d = (state_d != FLUSH);
  end

  assign top_c   = (out_row_q == '0);
  assign bot_c   = (out_row_q == CW'(W - 1));
  assign left_c  = (out_col_q == '0);
  assign right_c = (out_col_q == CW'(W - 1));
  assign last_c  = emit_c & bot_c & right_c;

  // Zero every tap that falls outside the image around the current centre.
  for (genvar k = 0; k < TAPS_3x3; k++) begin : g_win
    localparam int unsigned DY = k / 3;
    localparam int unsigned DX = k % 3;
    logic pad_c;
    assign pad_c = ((DY == 0) && top_c) || ((DY == 2) && bot_c) ||
                   ((DX == 0) && left_c) || ((DX == 2) && right_c);
    assign window_c[k] = pad_c ? '0 : taps_c[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FILL;
      in_cnt_q     <= '0;
      flush_cnt_q  <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      ready_q      <= 1'b1;
      overrun_q    <= 1'b0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
      data_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      in_cnt_q     <= in_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      ready_q      <= ready_d;
      overrun_q    <= overrun_d;
      valid_out_q  <= emit_c;
      frame_done_q <= last_c;
      if (emit_c) data_out_q <= window_c;
    end
  end

  assign bus.ready_in   = ready_q;
  assign bus.overrun    = overrun_q;
  assign bus.valid_out  = valid_out_q;
  assign bus.frame_done = frame_done_q;
  assign bus.data_out   = data_out_q;

endmodule

// File: tb/tb_window3x3_linebuf.sv
// Directed bench for window3x3_linebuf at IMG_SIZE=4; pixel n of each frame carries n+1.
module tb_window3x3_linebuf;

  localparam int unsigned DW = 32;
  localparam int unsigned W  = 4;
  typedef logic [9*DW-1:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  window3x3_linebuf_if #(.DATA_WIDTH(DW)) bus ();

  window3x3_linebuf #(.DATA_WIDTH(DW), .IMG_SIZE(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input vec_t got, input vec_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Hand-computed windows, listed k=0..8.
  int unsigned h_first[9] = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
  int unsigned h_c7[9]    = '{3, 4, 0, 7, 8, 0, 11, 12, 0};
  int unsigned h_c8[9]    = '{0, 5, 6, 0, 9, 10, 0, 13, 14};
  int unsigned h_c12[9]   = '{0, 9, 10, 0, 13, 14, 0, 0, 0};
  int unsigned h_last[9]  = '{11, 12, 0, 15, 16, 0, 0, 0, 0};

  function automatic vec_t pack9(input int unsigned t[9]);
    vec_t v = '0;
    for (int k = 0; k < 9; k++) v[k*DW +: DW] = t[k];
    return v;
  endfunction

  function automatic vec_t ref_win(input int c);
    vec_t v = '0;
    int r, col, rr, cc;
    r   = c / W;
    col = c % W;
    for (int k = 0; k < 9; k++) begin
      rr = r + k / 3 - 1;
      cc = col + k % 3 - 1;
      if (rr >= 0 && rr < W && cc >= 0 && cc < W) v[k*DW +: DW] = DW'(rr * W + cc + 1);
    end
    return v;
  endfunction

  // Reference behaviour, stepped once per cycle between clock edges.
  int   m_st = 0, m_n = 0, m_fl = 0, m_c = 0;
  bit   m_ovr = 1'b0;
  bit   exp_v = 1'b0, exp_rdy = 1'b1, exp_ovr = 1'b0, exp_fd = 1'b0;
  int   exp_c = 0;
  int   win_total = 0, fd_total = 0;
  vec_t got_win [16];

  always @(negedge clk) begin
    if (rst) begin
      m_st = 0; m_n = 0; m_fl = 0; m_c = 0; m_ovr = 1'b0;
      exp_v = 1'b0; exp_rdy = 1'b1; exp_ovr = 1'b0; exp_fd = 1'b0;
    end
    check("valid_out", vec_t'(bus.valid_out), vec_t'(exp_v));
    check("ready_in", vec_t'(bus.ready_in), vec_t'(exp_rdy));
    check("overrun", vec_t'(bus.overrun), vec_t'(exp_ovr));
    check("frame_done", vec_t'(bus.frame_done), vec_t'(exp_v & exp_fd));
    if (exp_v && bus.valid_out) begin
      check("window", bus.data_out, ref_win(exp_c));
      got_win[exp_c] = bus.data_out;
      win_total++;
      if (bus.frame_done) fd_total++;
    end
    if (!rst) begin
      exp_v = 1'b0;
      if (bus.valid_in && m_st == 2) m_ovr = 1'b1;
      case (m_st)
        0: if (bus.valid_in) begin
             m_n++;
             if (m_n == W + 1) m_st = 1;
           end
        1: if (bus.valid_in) begin
             exp_v = 1'b1; exp_c = m_c; m_c++; m_n++;
             if (m_n == W * W) begin m_st = 2; m_fl = 0; end
           end
        default: begin
             exp_v = 1'b1; exp_c = m_c; m_c++; m_fl++;
             if (m_fl == W + 1) begin m_st = 0; m_n = 0; m_c = 0; end
           end
      endcase
      exp_fd  = (exp_c == W * W - 1);
      exp_rdy = (m_st != 2);
      exp_ovr = m_ovr;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_pixel(input int unsigned v);
    int t = 0;
    while (bus.ready_in !== 1'b1 && t < 50) begin tick(1); t++; end
    if (t >= 50) check("ready_timeout", vec_t'(bus.ready_in), vec_t'(1));
    bus.valid_in = 1'b1;
    bus.data_in  = v;
    tick(1);
    bus.valid_in = 1'b0;
  endtask

  task automatic send_frame(input int gap);
    for (int n = 0; n < W * W; n++) begin
      drive_pixel(n + 1);
      tick(gap);
    end
  endtask

  task automatic clear_log();
    for (int i = 0; i < 16; i++) got_win[i] = '1;
  endtask

  int w0, f0;

  initial begin
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    tick(3);
    rst = 1'b0;
    tick(2);

    // Continuous frame plus first-window latency and edge windows.
    clear_log();
    w0 = win_total; f0 = fd_total;
    for (int n = 0; n < W * W; n++) begin
      drive_pixel(n + 1);
      if (n == 4 || n == 5) check("first_latency", vec_t'(bus.valid_out), vec_t'(n == 5));
    end
    tick(8);
    check("win_first", got_win[0], pack9(h_first));
    check("win_c1_3", got_win[7], pack9(h_c7));
    check("win_c2_0", got_win[8], pack9(h_c8));
    check("win_last", got_win[15], pack9(h_last));
    check("frame_windows", vec_t'(win_total - w0), vec_t'(16));
    check("frame_done_cnt", vec_t'(fd_total - f0), vec_t'(1));

    // Gapped input, one pixel every fourth cycle.
    clear_log();
    w0 = win_total;
    send_frame(3);
    tick(8);
    check("gap_windows", vec_t'(win_total - w0), vec_t'(16));
    check("gap_first", got_win[0], pack9(h_first));
    check("gap_last", got_win[15], pack9(h_last));

    // valid_in held during flush: sticky overrun, flush windows unaffected.
    clear_log();
    for (int n = 0; n < W * W; n++) drive_pixel(n + 1);
    bus.valid_in = 1'b1;
    bus.data_in  = 32'hDEAD_BEEF;
    tick(3);
    bus.valid_in = 1'b0;
    tick(6);
    check("overrun_set", vec_t'(bus.overrun), vec_t'(1));
    check("ovr_c3_0", got_win[12], pack9(h_c12));
    check("ovr_last", got_win[15], pack9(h_last));
    tick(4);
    check("overrun_sticky", vec_t'(bus.overrun), vec_t'(1));

    // Reset after nine pixels, then two back-to-back frames.
    for (int n = 0; n < 9; n++) drive_pixel(n + 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_valid", vec_t'(bus.valid_out), vec_t'(0));
    check("rst_ready", vec_t'(bus.ready_in), vec_t'(1));
    check("rst_overrun", vec_t'(bus.overrun), vec_t'(0));
    check("rst_data", bus.data_out, vec_t'(0));
    tick(1);
    rst = 1'b0;
    clear_log();
    w0 = win_total; f0 = fd_total;
    send_frame(0);
    send_frame(0);
    tick(8);
    check("b2b_windows", vec_t'(win_total - w0), vec_t'(32));
    check("b2b_frame_done", vec_t'(fd_total - f0), vec_t'(2));
    check("b2b_last", got_win[15], pack9(h_last));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
